// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Entry widths follow DEF_ADDR_W / DEF_INSTR_W; the top-level widths must match them.
package ifetch_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 8;

    localparam logic [3:0] OPC_HALT = 4'b1111;
    localparam logic [3:0] OPC_JUMP = 4'b1110;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Show-ahead instruction buffer: DEPTH entries of fetch_entry_t with push/pop/flush.
// Flush wins over push and pop; the head entry is readable combinationally.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push;
    logic           do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push && !reset) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, issues imem reads, buffers responses and hands them to decode.
// Optional perf counters (perf_fetched / perf_flushed) are built when IFETCH_PERF_EN is defined.
module instr_fetch_stage
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               halt,
    output logic               halted
`ifdef IFETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_flushed
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               inflight_q;
    logic [ADDR_W-1:0]  inflight_pc_q;

    logic               req;
    logic               flush;
    logic               push;
    logic               pop;
    logic [CW-1:0]      count;
    logic [CW-1:0]      occupancy;
    logic               empty;
    fetch_entry_t       head;
    fetch_entry_t       wdata;

    assign occupancy = count + CW'(inflight_q);
    assign wdata     = '{instr: imem_rdata, pc: inflight_pc_q};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush   = 1'b0;
        req     = 1'b0;
        if (state_q == RUN) begin
            flush = redirect;
            // Limit counts every entry that will eventually occupy a slot; a pop this cycle is not credited.
            req   = ~redirect & ~halt & (occupancy < CW'(DEPTH));
            if (halt) begin
                state_d = HALTED;
            end else if (redirect) begin
                pc_d = redirect_target;
            end else if (req) begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    assign push = inflight_q & ~flush;
    assign pop  = ~empty & instr_ready & ~flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= PC_RESET;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= req;
            inflight_pc_q <= pc_q;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata),
        .head  (head),
        .count (count),
        .empty (empty)
    );

    // Every output is forced low while reset is held.
    assign imem_req    = req & ~reset;
    assign imem_addr   = imem_req ? pc_q : '0;
    assign instr_valid = ~empty & ~reset;
    assign instr       = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;
    assign halted      = (state_q == HALTED) & ~reset;

`ifdef IFETCH_PERF_EN
    logic [15:0] perf_fetched_q;
    logic [15:0] perf_flushed_q;
    logic [16:0] flushed_sum;

    assign flushed_sum = {1'b0, perf_flushed_q} + 17'(count) + 17'(inflight_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (push && perf_fetched_q != 16'hFFFF) begin
                perf_fetched_q <= perf_fetched_q + 16'd1;
            end
            if (flush) begin
                perf_flushed_q <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule
